// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill logic.
//   - fill_state_t : fill controller state encoding (IDLE, ISSUE, WAIT)
//   - block geometry: words per block, bytes per word, counter width
//   - bit positions of the word offset and the set index within an address
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_BYTES      = 2;
    localparam int DATA_W          = 16;

    // Width of the per-fill word counters (one count per word in a block).
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);

    // Byte-to-word shift: word offset starts above the byte-select bits.
    localparam int OFFSET_LSB = $clog2(WORD_BYTES);

    // Set index starts just above the block offset (byte + word bits).
    localparam int BLOCK_BYTES = WORD_BYTES * WORDS_PER_BLOCK;
    localparam int INDEX_LSB   = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fill_state_t;

endpackage

// File: rtl/fill_counter.sv
// Small up-counter used for the issue and receive word counts of a fill.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset, count returns to 0
//   clr   : synchronous clear to 0 (takes priority over en)
//   en    : increment by one, wrapping modulo 2^W
//   count : current count
//   tc    : terminal count flag, high when count is all ones
module fill_counter
    import cache_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Count register: clear has priority, otherwise increment when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == {W{1'b1}});

endmodule

// File: rtl/cache_fill_controller.sv
// Miss-fill controller for the cache data and tag arrays.
// On a sampled miss it latches the block base address, issues one word
// address per cycle to main memory, writes each returned word into the data
// array at its word offset, and strobes the tag array with the last word.
//   clk, rst          : clock (rising edge) and asynchronous active-high reset
//   miss_detected     : miss strobe, only looked at while idle
//   miss_address      : address of the missing access
//   fsm_busy          : high while a fill is in progress (pipeline stall)
//   mem_en            : memory read request, one word address per cycle
//   memory_address    : word address sent to memory
//   memory_data_valid : a returned word is present this cycle
//   memory_data_in    : returned word
//   write_data_array  : data-array write enable
//   data_array_wdata  : data-array write data (memory_data_in passed through)
//   word_index        : word offset within the block for the current write
//   block_index       : latched set index, feeds the wordline decoder
//   write_tag_array   : one-cycle tag write strobe on fill completion
module cache_fill_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INDEX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss_detected,
    input  logic [ADDR_W-1:0]  miss_address,
    output logic               fsm_busy,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  memory_address,
    input  logic               memory_data_valid,
    input  logic [DATA_W-1:0]  memory_data_in,
    output logic               write_data_array,
    output logic [DATA_W-1:0]  data_array_wdata,
    output logic [CNT_W-1:0]   word_index,
    output logic [INDEX_W-1:0] block_index,
    output logic               write_tag_array
);

    localparam int INDEX_MSB = INDEX_LSB + INDEX_W - 1;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(BLOCK_BYTES - 1);

    fill_state_t        state_r;
    fill_state_t        state_next_s;
    logic [ADDR_W-1:0]  base_r;
    logic [INDEX_W-1:0] block_index_r;
    logic [ADDR_W-1:0]  miss_base_s;
    logic [ADDR_W-1:0]  offset_s;

    logic               latch_s;
    logic               issue_en_s;
    logic               accept_s;
    logic               complete_s;
    logic               recv_en_s;
    logic               busy_s;
    logic               mem_en_s;

    logic [CNT_W-1:0]   issue_cnt_s;
    logic [CNT_W-1:0]   recv_cnt_s;
    logic               issue_tc_s;
    logic               recv_tc_s;

    // Block-aligned base of the incoming miss: drop the byte and word offset.
    assign miss_base_s = miss_address & ~OFFSET_MASK;

    fill_counter #(.W(CNT_W)) issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (latch_s),
        .en    (issue_en_s),
        .count (issue_cnt_s),
        .tc    (issue_tc_s)
    );

    fill_counter #(.W(CNT_W)) recv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (latch_s),
        .en    (recv_en_s),
        .count (recv_cnt_s),
        .tc    (recv_tc_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Miss latch: base address and set index held from the miss until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_r        <= {ADDR_W{1'b0}};
            block_index_r <= {INDEX_W{1'b0}};
        end else if (latch_s) begin
            base_r        <= miss_base_s;
            block_index_r <= miss_base_s[INDEX_MSB:INDEX_LSB];
        end else begin
            base_r        <= base_r;
            block_index_r <= block_index_r;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        issue_en_s   = 1'b0;
        accept_s     = 1'b0;
        complete_s   = 1'b0;
        busy_s       = 1'b0;
        mem_en_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (miss_detected) begin
                    latch_s      = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                busy_s     = 1'b1;
                mem_en_s   = 1'b1;
                // Saturate at the last word: the counter is not reused after 7.
                issue_en_s = ~issue_tc_s;
                accept_s   = memory_data_valid;
                // The last word may only complete once its own issue is going out.
                complete_s = memory_data_valid & recv_tc_s & issue_tc_s;
                if (complete_s) begin
                    state_next_s = IDLE;
                end else if (issue_tc_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT: begin
                busy_s     = 1'b1;
                accept_s   = memory_data_valid;
                complete_s = memory_data_valid & recv_tc_s;
                if (complete_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // recv_cnt wraps back to 0 only on the completing word.
        recv_en_s = accept_s & (~recv_tc_s | complete_s);
    end

    assign offset_s = ADDR_W'(issue_cnt_s) << OFFSET_LSB;

    assign fsm_busy         = busy_s;
    assign mem_en           = mem_en_s;
    assign memory_address   = mem_en_s ? (base_r + offset_s) : {ADDR_W{1'b0}};
    assign write_data_array = accept_s;
    assign data_array_wdata = memory_data_in;
    assign word_index       = accept_s ? recv_cnt_s : {CNT_W{1'b0}};
    assign block_index      = block_index_r;
    assign write_tag_array  = complete_s;

endmodule

// File: tb/tb_cache_fill_controller.sv
// Self-checking bench for cache_fill_controller with a fixed-latency memory
// model and scoreboard queues of expected addresses and data-array writes.
module tb_cache_fill_controller;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data_in;
    logic        write_data_array;
    logic [15:0] data_array_wdata;
    logic [2:0]  word_index;
    logic [5:0]  block_index;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_controller dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data_in    (memory_data_in),
        .write_data_array  (write_data_array),
        .data_array_wdata  (data_array_wdata),
        .word_index        (word_index),
        .block_index       (block_index),
        .write_tag_array   (write_tag_array)
    );

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
    } wr_t;

    mreq_t       mem_q[$];
    logic [15:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bit          m_busy = 1'b0;
    int          m_issue = 0;
    int          m_recv = 0;
    logic [5:0]  m_block = 6'd0;
    bit          gap_mode = 1'b0;
    int          wr_seen = 0;
    int          tag_seen = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        check_eq({tag, "_busy"}, {31'd0, fsm_busy}, 32'd0);
        check_eq({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        check_eq({tag, "_maddr"}, {16'd0, memory_address}, 32'd0);
        check_eq({tag, "_wr"}, {31'd0, write_data_array}, 32'd0);
        check_eq({tag, "_widx"}, {29'd0, word_index}, 32'd0);
        check_eq({tag, "_tag"}, {31'd0, write_tag_array}, 32'd0);
    endtask

    // One clock: drive inputs at the falling edge, check just after, update the model.
    task automatic tick(input logic miss, input logic [15:0] maddr,
                        input logic fvalid, input logic [15:0] fdata);
        mreq_t       r;
        wr_t         w;
        logic [15:0] a;
        logic [15:0] base;
        bit          e_mem_en;
        bit          e_wr;
        bit          e_tag;
        @(negedge clk);
        miss_detected     = miss;
        miss_address      = maddr;
        memory_data_valid = 1'b0;
        memory_data_in    = 16'd0;
        if (fvalid) begin
            memory_data_valid = 1'b1;
            memory_data_in    = fdata;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
                     (!gap_mode || $urandom_range(0, 2) == 0)) begin
            r = mem_q.pop_front();
            memory_data_valid = 1'b1;
            memory_data_in    = mem_word(r.addr);
        end
        #1;
        e_mem_en = !rst && m_busy && (m_issue < 8);
        e_wr     = !rst && m_busy && memory_data_valid;
        e_tag    = e_wr && (m_recv == 7);
        check_eq("busy", {31'd0, fsm_busy}, {31'd0, m_busy});
        check_eq("mem_en", {31'd0, mem_en}, {31'd0, e_mem_en});
        if (mem_en) begin
            check_eq("addr_avail", {31'd0, exp_addr_q.size() > 0}, 32'd1);
            if (exp_addr_q.size() > 0) begin
                a = exp_addr_q.pop_front();
                check_eq("mem_addr", {16'd0, memory_address}, {16'd0, a});
            end
            mem_q.push_back('{memory_address, cyc + LAT});
        end
        check_eq("wr_en", {31'd0, write_data_array}, {31'd0, e_wr});
        if (write_data_array) begin
            wr_seen++;
            check_eq("wr_avail", {31'd0, exp_wr_q.size() > 0}, 32'd1);
            if (exp_wr_q.size() > 0) begin
                w = exp_wr_q.pop_front();
                check_eq("word_index", {29'd0, word_index}, {29'd0, w.idx});
                check_eq("wdata", {16'd0, data_array_wdata}, {16'd0, w.data});
            end
        end
        check_eq("tag", {31'd0, write_tag_array}, {31'd0, e_tag});
        if (write_tag_array) tag_seen++;
        check_eq("block_index", {26'd0, block_index}, {26'd0, m_block});
        if (rst) begin
            m_busy = 1'b0; m_block = 6'd0; m_issue = 0; m_recv = 0;
        end else if (m_busy) begin
            if (e_mem_en) m_issue++;
            if (e_wr) m_recv++;
            if (e_tag) begin m_busy = 1'b0; m_recv = 0; end
        end else if (miss) begin
            base    = maddr & 16'hFFF0;
            m_busy  = 1'b1;
            m_block = maddr[9:4];
            m_issue = 0;
            m_recv  = 0;
            for (int i = 0; i < 8; i++) begin
                a = base + 16'(2 * i);
                exp_addr_q.push_back(a);
                exp_wr_q.push_back('{3'(i), mem_word(a)});
            end
        end
        cyc++;
    endtask

    task automatic do_fill(input logic [15:0] addr, input bit gaps, input bit extras);
        int n;
        wr_seen  = 0;
        tag_seen = 0;
        gap_mode = gaps;
        tick(1'b1, addr, 1'b0, 16'd0);
        n = 0;
        while (m_busy && n < 400) begin
            tick(extras && ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0, 16'd0);
            n++;
        end
        check_eq("fill_done", {31'd0, m_busy}, 32'd0);
        check_eq("wr_count", wr_seen, 32'd8);
        check_eq("tag_count", tag_seen, 32'd1);
        check_eq("addr_q_left", exp_addr_q.size(), 32'd0);
        check_eq("wr_q_left", exp_wr_q.size(), 32'd0);
        gap_mode = 1'b0;
    endtask

    initial begin
        int n;
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'd0;
        memory_data_valid = 1'b0;
        memory_data_in    = 16'd0;

        // Reset held: everything quiet.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'd0, 1'b0, 16'd0);
            chk_zero("rst");
            check_eq("rst_wdata", {16'd0, data_array_wdata}, 32'd0);
            check_eq("rst_blk", {26'd0, block_index}, 32'd0);
        end
        rst = 1'b0;

        // Idle with stray returned words: no writes.
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 16'h1234, 1'(i % 2), 16'hBEEF);
            chk_zero("idle");
        end

        // Basic fill.
        do_fill(16'h1234, 1'b0, 1'b0);
        check_eq("basic_block", {26'd0, block_index}, 32'h23);
        tick(1'b0, 16'd0, 1'b0, 16'd0);
        check_eq("busy_fall", {31'd0, fsm_busy}, 32'd0);
        check_eq("blk_hold", {26'd0, block_index}, 32'h23);

        // Top-of-memory block: no carry past 16 bits.
        do_fill(16'hFFF8, 1'b0, 1'b0);
        check_eq("wrap_block", {26'd0, block_index}, 32'h3F);

        // Random return gaps and ignored extra misses.
        do_fill(16'hA5C6, 1'b1, 1'b1);
        check_eq("gap_block", {26'd0, block_index}, 32'h1C);

        // Abort after the third returned word.
        wr_seen  = 0;
        tag_seen = 0;
        tick(1'b1, 16'h2468, 1'b0, 16'd0);
        n = 0;
        while (m_recv < 3 && n < 100) begin
            tick(1'b0, 16'd0, 1'b0, 16'd0);
            n++;
        end
        check_eq("abort_reach", m_recv, 32'd3);
        rst = 1'b1;
        m_busy = 1'b0; m_block = 6'd0; m_issue = 0; m_recv = 0;
        exp_addr_q.delete();
        exp_wr_q.delete();
        #1;
        chk_zero("abort");
        check_eq("abort_blk", {26'd0, block_index}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'd0, 1'b0, 16'd0);
            chk_zero("abort_hold");
        end
        check_eq("abort_no_tag", tag_seen, 32'd0);
        check_eq("abort_wr", wr_seen, 32'd3);
        rst = 1'b0;
        // Late returns from the aborted fill land in IDLE and must be dropped.
        n = 0;
        while (mem_q.size() > 0 && n < 50) begin
            tick(1'b0, 16'd0, 1'b0, 16'd0);
            n++;
        end
        do_fill(16'h0040, 1'b0, 1'b0);
        check_eq("after_abort_block", {26'd0, block_index}, 32'h04);

        // Back-to-back: second miss in the first idle cycle after completion.
        do_fill(16'h3000, 1'b0, 1'b0);
        do_fill(16'h3016, 1'b0, 1'b0);
        check_eq("b2b_block", {26'd0, block_index}, 32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
